pipe_stage_reg: RTL and testbench

Parametrised multi-stage pipeline register with valid tracking, stall (hold) and flush (bubble insertion). It replaces single-bit flip-flops between CPU pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB). The hazard unit can freeze or squash a whole WIDTH-bit stage bundle in one cycle, and DEPTH > 1 gives a balanced multi-cycle delay line (e.g. a multi-cycle multiplier path).

---
 rtl/pipe_stage_reg.sv | 81 ++++++++
 tb/tb_pipe_stage_reg.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: multi-stage pipeline register with valid, stall, flush.
// Optional stall counter built when PIPE_STAGE_REG_STALL_CNT_EN is defined.
module pipe_stage_reg #(
    parameter int unsigned      WIDTH     = 64,
    parameter int unsigned      DEPTH     = 1,
    parameter logic [WIDTH-1:0] NOP_VALUE = '0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [WIDTH-1:0]           d,
    input  logic                       d_valid,
    input  logic                       stall,
    input  logic                       flush,
    output logic [WIDTH-1:0]           q,
    output logic                       q_valid,
    output logic [$clog2(DEPTH+1)-1:0] occupancy,
    output logic [15:0]                stall_cnt
);

    localparam int unsigned OCC_W = $clog2(DEPTH + 1);

    if (DEPTH < 1 || DEPTH > 8) begin : g_bad_depth
        $error("pipe_stage_reg: DEPTH must be 1..8");
    end

    logic [WIDTH-1:0] data_r [DEPTH];
    logic [DEPTH-1:0] valid_r;

    // Stage registers: reset/flush squash to bubbles, stall holds, else shift.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                data_r[i] <= NOP_VALUE;
            end
            valid_r <= '0;
        end else if (flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                data_r[i] <= NOP_VALUE;
            end
            valid_r <= '0;
        end else if (!stall) begin
            data_r[0]  <= d_valid ? d : NOP_VALUE;
            valid_r[0] <= d_valid;
            for (int i = 1; i < DEPTH; i++) begin
                data_r[i]  <= data_r[i-1];
                valid_r[i] <= valid_r[i-1];
            end
        end
    end

    assign q       = data_r[DEPTH-1];
    assign q_valid = valid_r[DEPTH-1];

    // Popcount of the valid bits; purely from registers.
    always_comb begin
        occupancy = '0;
        for (int i = 0; i < DEPTH; i++) begin
            occupancy = occupancy + OCC_W'(valid_r[i]);
        end
    end

`ifdef PIPE_STAGE_REG_STALL_CNT_EN
    logic [15:0] cnt_r;

    // Count stalled cycles that actually freeze live data, saturating.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_r <= '0;
        end else if (flush) begin
            cnt_r <= '0;
        end else if (stall && occupancy != '0 && cnt_r != 16'hFFFF) begin
            cnt_r <= cnt_r + 16'd1;
        end
    end

    assign stall_cnt = cnt_r;
`else
    assign stall_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: vectors, hand sequences and a queue-based model
// driving DEPTH=1,2,3 instances with shared inputs.
module tb_pipe_stage_reg;

    localparam logic [31:0] NOP = 32'h00000013;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] d;
    logic        d_valid, stall, flush;

    logic [31:0] q1, q2, q3;
    logic        qv1, qv2, qv3;
    logic [0:0]  occ1;
    logic [1:0]  occ2, occ3;
    logic [15:0] sc1, sc2, sc3;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipe_stage_reg #(.WIDTH(32), .DEPTH(1), .NOP_VALUE(NOP)) u1 (
        .clk(clk), .reset(reset), .d(d), .d_valid(d_valid),
        .stall(stall), .flush(flush), .q(q1), .q_valid(qv1),
        .occupancy(occ1), .stall_cnt(sc1)
    );

    pipe_stage_reg #(.WIDTH(32), .DEPTH(2), .NOP_VALUE(NOP)) u2 (
        .clk(clk), .reset(reset), .d(d), .d_valid(d_valid),
        .stall(stall), .flush(flush), .q(q2), .q_valid(qv2),
        .occupancy(occ2), .stall_cnt(sc2)
    );

    pipe_stage_reg #(.WIDTH(32), .DEPTH(3), .NOP_VALUE(NOP)) u3 (
        .clk(clk), .reset(reset), .d(d), .d_valid(d_valid),
        .stall(stall), .flush(flush), .q(q3), .q_valid(qv3),
        .occupancy(occ3), .stall_cnt(sc3)
    );

    // Reference model: each pipeline is a queue of in-flight entries,
    // front = newest, back = output stage.
    typedef struct packed {
        logic [31:0] d;
        logic        v;
    } ent_t;

    ent_t m1[$], m2[$], m3[$];
    int   msc[3];

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int count_valid(ent_t m[$]);
        int n = 0;
        foreach (m[i]) n += int'(m[i].v);
        return n;
    endfunction

    task automatic model_clear();
        ent_t b;
        b.d = NOP;
        b.v = 1'b0;
        m1.delete(); m2.delete(); m3.delete();
        m1.push_back(b);
        repeat (2) m2.push_back(b);
        repeat (3) m3.push_back(b);
    endtask

    task automatic model_edge(logic [31:0] di, logic dv, logic st, logic fl);
        ent_t e;
        int o[3];
        o[0] = count_valid(m1);
        o[1] = count_valid(m2);
        o[2] = count_valid(m3);
        if (fl) begin
            model_clear();
            msc = '{0, 0, 0};
        end else if (st) begin
`ifdef PIPE_STAGE_REG_STALL_CNT_EN
            for (int k = 0; k < 3; k++)
                if (o[k] > 0 && msc[k] < 65535) msc[k]++;
`endif
        end else begin
            e.d = dv ? di : NOP;
            e.v = dv;
            m1.push_front(e); void'(m1.pop_back());
            m2.push_front(e); void'(m2.pop_back());
            m3.push_front(e); void'(m3.pop_back());
        end
    endtask

    task automatic step(logic [31:0] di, logic dv, logic st, logic fl);
        d = di; d_valid = dv; stall = st; flush = fl;
        @(posedge clk);
        model_edge(di, dv, st, fl);
        #1;
    endtask

    task automatic check_model();
        chk("m1_q",   q1, m1[0].d);
        chk("m1_qv",  32'(qv1), 32'(m1[0].v));
        chk("m1_occ", 32'(occ1), 32'(count_valid(m1)));
        chk("m1_sc",  32'(sc1), 32'(msc[0]));
        chk("m2_q",   q2, m2[1].d);
        chk("m2_qv",  32'(qv2), 32'(m2[1].v));
        chk("m2_occ", 32'(occ2), 32'(count_valid(m2)));
        chk("m2_sc",  32'(sc2), 32'(msc[1]));
        chk("m3_q",   q3, m3[2].d);
        chk("m3_qv",  32'(qv3), 32'(m3[2].v));
        chk("m3_occ", 32'(occ3), 32'(count_valid(m3)));
        chk("m3_sc",  32'(sc3), 32'(msc[2]));
    endtask

    typedef struct {
        logic [31:0] d;
        logic        dv, st, fl;
        logic [31:0] eq;
        logic        eqv;
        int          eocc;
    } vec_t;

    vec_t tbl[12];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] exp_sc;
        logic [31:0] bq[5];
        logic        bv[5];

        // DEPTH=3 stream, stall with stages 5,6,7, then flush+stall.
        tbl[0]  = '{32'd1, 1'b1, 1'b0, 1'b0, NOP,   1'b0, 1};
        tbl[1]  = '{32'd2, 1'b1, 1'b0, 1'b0, NOP,   1'b0, 2};
        tbl[2]  = '{32'd3, 1'b1, 1'b0, 1'b0, 32'd1, 1'b1, 3};
        tbl[3]  = '{32'd4, 1'b1, 1'b0, 1'b0, 32'd2, 1'b1, 3};
        tbl[4]  = '{32'd5, 1'b1, 1'b0, 1'b0, 32'd3, 1'b1, 3};
        tbl[5]  = '{32'd6, 1'b1, 1'b0, 1'b0, 32'd4, 1'b1, 3};
        tbl[6]  = '{32'd7, 1'b1, 1'b0, 1'b0, 32'd5, 1'b1, 3};
        tbl[7]  = '{32'd8, 1'b1, 1'b1, 1'b0, 32'd5, 1'b1, 3};
        tbl[8]  = '{32'd8, 1'b1, 1'b1, 1'b0, 32'd5, 1'b1, 3};
        tbl[9]  = '{32'd8, 1'b1, 1'b0, 1'b0, 32'd6, 1'b1, 3};
        tbl[10] = '{32'd9, 1'b1, 1'b1, 1'b1, NOP,   1'b0, 0};
        tbl[11] = '{32'd0, 1'b0, 1'b0, 1'b0, NOP,   1'b0, 0};

`ifdef PIPE_STAGE_REG_STALL_CNT_EN
        exp_sc = 32'd2;
`else
        exp_sc = 32'd0;
`endif

        reset = 1'b1; d = '0; d_valid = 0; stall = 0; flush = 0;
        model_clear();
        msc = '{0, 0, 0};
        #12;
        chk("rst_q",   q3, NOP);
        chk("rst_qv",  32'(qv3), 32'd0);
        chk("rst_occ", 32'(occ3), 32'd0);
        chk("rst_sc",  32'(sc3), 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 12; i++) begin
            step(tbl[i].d, tbl[i].dv, tbl[i].st, tbl[i].fl);
            chk($sformatf("tbl%0d_q", i), q3, tbl[i].eq);
            chk($sformatf("tbl%0d_qv", i), 32'(qv3), 32'(tbl[i].eqv));
            chk($sformatf("tbl%0d_occ", i), 32'(occ3), 32'(tbl[i].eocc));
            if (i == 8) chk("stall_cnt_2", 32'(sc3), exp_sc);
            if (i == 10) chk("flush_sc", 32'(sc3), 32'd0);
        end

        // Bubble: DEPTH=2, valid pattern 1,0,1; B must never show.
        bq = '{32'hAAAA0001, 32'hAAAA0001, NOP, 32'hCCCC0003, NOP};
        bv = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        step(32'hAAAA0001, 1'b1, 1'b0, 1'b0);
        chk("bub0_q",  q2, NOP);
        chk("bub0_qv", 32'(qv2), 32'(bv[0]));
        step(32'hBBBB0002, 1'b0, 1'b0, 1'b0);
        chk("bub1_q",  q2, bq[1]);
        chk("bub1_qv", 32'(qv2), 32'(bv[1]));
        step(32'hCCCC0003, 1'b1, 1'b0, 1'b0);
        chk("bub2_q",  q2, bq[2]);
        chk("bub2_qv", 32'(qv2), 32'(bv[2]));
        step(32'hBBBB0002, 1'b0, 1'b0, 1'b0);
        chk("bub3_q",  q2, bq[3]);
        chk("bub3_qv", 32'(qv2), 32'(bv[3]));
        step(32'hBBBB0002, 1'b0, 1'b0, 1'b0);
        chk("bub4_q",  q2, bq[4]);
        chk("bub4_qv", 32'(qv2), 32'(bv[4]));

        // Asynchronous reset mid-cycle with full pipes.
        for (int i = 0; i < 3; i++) step(32'h100 + i, 1'b1, 1'b0, 1'b0);
        #2 reset = 1'b1;
        #1;
        chk("async_q",   q3, NOP);
        chk("async_qv",  32'(qv3), 32'd0);
        chk("async_occ", 32'(occ3), 32'd0);
        #1 reset = 1'b0;
        model_clear();
        msc = '{0, 0, 0};
        step(32'h55, 1'b1, 1'b0, 1'b0);
        chk("post_rst_occ", 32'(occ3), 32'd1);

        // Randomized traffic against the queue model.
        for (int n = 0; n < 400; n++) begin
            step($urandom, ($urandom_range(0, 9) < 7),
                 ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 12) == 0));
            check_model();
        end

        // Saturation: DEPTH=1 with one live stage, long stall.
        step(32'h0, 1'b0, 1'b0, 1'b1);
        step(32'h77, 1'b1, 1'b0, 1'b0);
        for (int n = 0; n < 65540; n++) step(32'h99, 1'b1, 1'b1, 1'b0);
`ifdef PIPE_STAGE_REG_STALL_CNT_EN
        chk("sat_sc", 32'(sc1), 32'h0000FFFF);
`else
        chk("sat_sc", 32'(sc1), 32'h0);
`endif
        chk("sat_q",  q1, 32'h77);
        chk("sat_qv", 32'(qv1), 32'd1);
        check_model();

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
